// File: rtl/fast_frame_sched.sv
// Frame-level sequencer for FAST_with_NMS: feeds one raster frame from a
// valid/ready source into the core and forwards its corners until end of frame.
module fast_frame_sched #(
  parameter int COL_NUM       = 640,
  parameter int ROW_NUM       = 480,
  parameter int PIXEL_WIDTH   = 8,
  parameter int COORD_W       = 10,
  parameter int MAX_CORNERS   = 2048,
  parameter int CNT_W         = 12,
  parameter int DRAIN_TIMEOUT = 8192
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   src_vld,
  input  logic [PIXEL_WIDTH-1:0] src_data,
  output logic                   src_rdy,
  output logic                   core_ce,
  output logic [PIXEL_WIDTH-1:0] core_data,
  input  logic                   core_iscorner,
  input  logic [COORD_W-1:0]     core_x,
  input  logic [COORD_W-1:0]     core_y,
  input  logic                   core_resize_eof,
  output logic                   corner_vld,
  output logic [COORD_W-1:0]     corner_x,
  output logic [COORD_W-1:0]     corner_y,
  output logic [CNT_W-1:0]       corner_cnt,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err,
  output logic                   overflow
);

  localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [COORD_W-1:0] COL_LAST  = COORD_W'(COL_NUM - 1);
  localparam logic [COORD_W-1:0] ROW_LAST  = COORD_W'(ROW_NUM - 1);
  localparam logic [CNT_W-1:0]   CAP       = CNT_W'(MAX_CORNERS);
  localparam logic [DW-1:0]      DRAIN_MAX = DW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [COORD_W-1:0] col, row;
  logic [DW-1:0]      drain_cnt;
  logic               eof_seen, last_seen;
  logic               active, accept, last_px, last_hit, ended, timeout_hit;
  logic               frame_start, take_corner, drop_corner, set_timeout;

  always_comb begin
    active      = (state == FEED) || (state == DRAIN);
    accept      = (state == FEED) && src_vld && !abort;
    last_px     = (col == COL_LAST) && (row == ROW_LAST);
    last_hit    = (core_x == COL_LAST) && (core_y == ROW_LAST);
    // Same-cycle eof / last coordinate count toward completion.
    ended       = (eof_seen || core_resize_eof) && (last_seen || last_hit);
    timeout_hit = (drain_cnt == DRAIN_MAX);
    frame_start = (state == IDLE) && start && !abort;
    take_corner = active && !abort && core_iscorner && (corner_cnt < CAP);
    drop_corner = active && !abort && core_iscorner && (corner_cnt >= CAP);
    set_timeout = (state == DRAIN) && !abort && !ended && timeout_hit;

    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = FEED;
      FEED: begin
        if (abort)                  state_next = IDLE;
        else if (accept && last_px) state_next = DRAIN;
      end
      DRAIN: begin
        if (abort)                      state_next = IDLE;
        else if (ended || timeout_hit)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      src_rdy     <= 1'b0;
      frame_done  <= 1'b0;
      core_ce     <= 1'b0;
      core_data   <= '0;
      corner_vld  <= 1'b0;
      corner_x    <= '0;
      corner_y    <= '0;
      corner_cnt  <= '0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
      col         <= '0;
      row         <= '0;
      drain_cnt   <= '0;
      eof_seen    <= 1'b0;
      last_seen   <= 1'b0;
    end else begin
      // Status outputs are registered from the next state so they align with it.
      state      <= state_next;
      busy       <= (state_next != IDLE);
      src_rdy    <= (state_next == FEED);
      frame_done <= (state_next == DONE);

      core_ce <= accept;
      if (accept) core_data <= src_data;

      corner_vld <= take_corner;
      if (take_corner) begin
        corner_x   <= core_x;
        corner_y   <= core_y;
        corner_cnt <= corner_cnt + 1'b1;
      end
      if (drop_corner) overflow    <= 1'b1;
      if (set_timeout) timeout_err <= 1'b1;

      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

      if (frame_start) begin
        col         <= '0;
        row         <= '0;
        corner_cnt  <= '0;
        timeout_err <= 1'b0;
        overflow    <= 1'b0;
        eof_seen    <= 1'b0;
        last_seen   <= 1'b0;
      end else begin
        if (accept) begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        if (active && core_resize_eof) eof_seen  <= 1'b1;
        if (active && last_hit)        last_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fast_frame_sched.sv
// Directed bench for fast_frame_sched on an 8x4 frame with a 3-corner cap;
// a second instance with a 16-cycle drain timeout covers the timeout path.
module tb_fast_frame_sched;

  localparam int CW = 10;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst, start, abort, src_vld;
  logic [7:0] src_data;
  logic core_iscorner, core_resize_eof;
  logic [CW-1:0] core_x, core_y;

  logic src_rdy, core_ce, corner_vld, busy, frame_done, timeout_err, overflow;
  logic [7:0] core_data;
  logic [CW-1:0] corner_x, corner_y;
  logic [NW-1:0] corner_cnt;

  logic t_src_rdy, t_core_ce, t_corner_vld, t_busy, t_frame_done, t_timeout_err, t_overflow;
  logic [7:0] t_core_data;
  logic [CW-1:0] t_corner_x, t_corner_y;
  logic [NW-1:0] t_corner_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fast_frame_sched #(.COL_NUM(8), .ROW_NUM(4), .PIXEL_WIDTH(8), .COORD_W(CW),
                     .MAX_CORNERS(3), .CNT_W(NW), .DRAIN_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_vld(src_vld), .src_data(src_data), .src_rdy(src_rdy),
    .core_ce(core_ce), .core_data(core_data),
    .core_iscorner(core_iscorner), .core_x(core_x), .core_y(core_y),
    .core_resize_eof(core_resize_eof),
    .corner_vld(corner_vld), .corner_x(corner_x), .corner_y(corner_y),
    .corner_cnt(corner_cnt), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .overflow(overflow));

  fast_frame_sched #(.COL_NUM(8), .ROW_NUM(4), .PIXEL_WIDTH(8), .COORD_W(CW),
                     .MAX_CORNERS(3), .CNT_W(NW), .DRAIN_TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_vld(src_vld), .src_data(src_data), .src_rdy(t_src_rdy),
    .core_ce(t_core_ce), .core_data(t_core_data),
    .core_iscorner(core_iscorner), .core_x(core_x), .core_y(core_y),
    .core_resize_eof(core_resize_eof),
    .corner_vld(t_corner_vld), .corner_x(t_corner_x), .corner_y(t_corner_y),
    .corner_cnt(t_corner_cnt), .busy(t_busy), .frame_done(t_frame_done),
    .timeout_err(t_timeout_err), .overflow(t_overflow));

  function automatic logic [7:0] pix(input int n);
    pix = 8'((n * 37 + 5) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_vld = 1'b0; src_data = '0;
    core_iscorner = 1'b0; core_resize_eof = 1'b0; core_x = '0; core_y = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Pushes 32 pixels from FEED; ends just after the final accept edge.
  task automatic feed_frame(input bit bubbles);
    int n = 0;
    int guard = 0;
    bit phase = 1'b1;
    bit acc;
    logic [7:0] exp_d;
    while (n < 32 && guard < 200) begin
      src_vld  = bubbles ? phase : 1'b1;
      src_data = pix(n);
      acc      = src_vld;
      exp_d    = pix(n);
      tick();
      phase = ~phase;
      guard++;
      vectors++;
      if (core_ce !== acc)
        begin miscompares++; $display("FAIL feed_ce n=%0d got=%b want=%b", n, core_ce, acc); end
      if (acc) begin
        n++;
        vectors++;
        if (core_data !== exp_d)
          begin miscompares++; $display("FAIL feed_data n=%0d got=%h want=%h", n, core_data, exp_d); end
        if (n < 32) begin
          vectors++;
          if (dut.col !== CW'(n % 8) || dut.row !== CW'(n / 8))
            begin miscompares++; $display("FAIL feed_pos n=%0d got=%0d,%0d want=%0d,%0d", n, dut.col, dut.row, n % 8, n / 8); end
        end
      end
      vectors++;
      if (src_rdy !== (n < 32))
        begin miscompares++; $display("FAIL feed_rdy n=%0d got=%b want=%b", n, src_rdy, n < 32); end
    end
    if (guard >= 200) begin miscompares++; $display("FAIL feed_budget accepts=%0d want=32", n); end
    src_vld = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({busy, src_rdy, core_ce, core_data, corner_vld, corner_x, corner_y, corner_cnt,
         frame_done, timeout_err, overflow} !== '0)
      begin miscompares++; $display("FAIL reset_outputs dut not all zero busy=%b rdy=%b", busy, src_rdy); end
    vectors++;
    if ({t_busy, t_src_rdy, t_core_ce, t_core_data, t_corner_vld, t_corner_x, t_corner_y,
         t_corner_cnt, t_frame_done, t_timeout_err, t_overflow} !== '0)
      begin miscompares++; $display("FAIL reset_outputs_t dut_t not all zero busy=%b", t_busy); end
  endtask

  task automatic test_nominal();
    do_reset();
    begin_frame();
    vectors++;
    if (busy !== 1'b1 || src_rdy !== 1'b1)
      begin miscompares++; $display("FAIL nom_enter busy=%b rdy=%b want 1 1", busy, src_rdy); end
    feed_frame(1'b0);
    for (int i = 1; i < 20; i++) begin
      tick();
      vectors++;
      if (frame_done !== 1'b0 || core_ce !== 1'b0 || busy !== 1'b1)
        begin miscompares++; $display("FAIL nom_drain i=%0d done=%b ce=%b busy=%b want 0 0 1", i, frame_done, core_ce, busy); end
    end
    core_resize_eof = 1'b1; core_x = CW'(7); core_y = CW'(3);
    tick();
    core_resize_eof = 1'b0; core_x = '0; core_y = '0;
    vectors++;
    if (frame_done !== 1'b1 || timeout_err !== 1'b0)
      begin miscompares++; $display("FAIL nom_done done=%b terr=%b want 1 0", frame_done, timeout_err); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (frame_done !== 1'b0 || busy !== 1'b0)
        begin miscompares++; $display("FAIL nom_once i=%0d done=%b busy=%b want 0 0", i, frame_done, busy); end
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    begin_frame();
    feed_frame(1'b1);
    vectors++;
    if (busy !== 1'b1 || src_rdy !== 1'b0)
      begin miscompares++; $display("FAIL bub_drain busy=%b rdy=%b want 1 0", busy, src_rdy); end
  endtask

  task automatic test_corner_cap();
    do_reset();
    begin_frame();
    for (int i = 0; i < 5; i++) begin
      core_iscorner = 1'b1; core_x = CW'(i + 1); core_y = CW'(2 * i);
      tick();
      vectors++;
      if (corner_vld !== (i < 3))
        begin miscompares++; $display("FAIL cap_vld i=%0d got=%b want=%b", i, corner_vld, i < 3); end
      if (i < 3) begin
        vectors++;
        if (corner_x !== CW'(i + 1) || corner_y !== CW'(2 * i))
          begin miscompares++; $display("FAIL cap_xy i=%0d got=%0d,%0d want=%0d,%0d", i, corner_x, corner_y, i + 1, 2 * i); end
      end
      vectors++;
      if (corner_cnt !== NW'((i < 3) ? i + 1 : 3) || overflow !== (i >= 3))
        begin miscompares++; $display("FAIL cap_cnt i=%0d cnt=%0d ovf=%b", i, corner_cnt, overflow); end
    end
    core_iscorner = 1'b0; core_x = '0; core_y = '0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || corner_cnt !== NW'(3) || overflow !== 1'b1 || corner_vld !== 1'b0)
      begin miscompares++; $display("FAIL cap_hold busy=%b cnt=%0d ovf=%b vld=%b want 0 3 1 0", busy, corner_cnt, overflow, corner_vld); end
  endtask

  task automatic test_timeout();
    do_reset();
    begin_frame();
    feed_frame(1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      vectors++;
      if (t_frame_done !== (i == 16))
        begin miscompares++; $display("FAIL to_done i=%0d got=%b want=%b", i, t_frame_done, i == 16); end
    end
    vectors++;
    if (t_timeout_err !== 1'b1)
      begin miscompares++; $display("FAIL to_err got=%b want=1", t_timeout_err); end
    tick();
    vectors++;
    if (t_frame_done !== 1'b0 || t_busy !== 1'b0 || t_timeout_err !== 1'b1 ||
        t_overflow !== 1'b0 || t_corner_cnt !== '0 || t_src_rdy !== 1'b0 || t_core_ce !== 1'b0)
      begin miscompares++; $display("FAIL to_after done=%b busy=%b terr=%b", t_frame_done, t_busy, t_timeout_err); end
  endtask

  task automatic test_early_eof();
    do_reset();
    begin_frame();
    core_resize_eof = 1'b1;
    tick();
    core_resize_eof = 1'b0;
    feed_frame(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (frame_done !== 1'b0)
        begin miscompares++; $display("FAIL eof_wait i=%0d got=%b want=0", i, frame_done); end
    end
    core_x = CW'(7); core_y = CW'(3);
    tick();
    core_x = '0; core_y = '0;
    vectors++;
    if (frame_done !== 1'b1 || timeout_err !== 1'b0 || corner_vld !== 1'b0)
      begin miscompares++; $display("FAIL eof_done done=%b terr=%b vld=%b want 1 0 0", frame_done, timeout_err, corner_vld); end
  endtask

  task automatic test_abort_start();
    do_reset();
    begin_frame();
    for (int i = 0; i < 10; i++) begin
      src_vld = 1'b1; src_data = pix(i); start = (i == 5);
      tick();
      vectors++;
      if (dut.col !== CW'((i + 1) % 8) || busy !== 1'b1)
        begin miscompares++; $display("FAIL busy_start i=%0d col=%0d busy=%b want %0d 1", i, dut.col, busy, (i + 1) % 8); end
    end
    start = 1'b0; abort = 1'b1; src_vld = 1'b1;
    tick();
    abort = 1'b0; src_vld = 1'b0;
    vectors++;
    if (busy !== 1'b0 || src_rdy !== 1'b0 || core_ce !== 1'b0 || corner_vld !== 1'b0 || frame_done !== 1'b0)
      begin miscompares++; $display("FAIL abort_idle busy=%b rdy=%b ce=%b done=%b want all 0", busy, src_rdy, core_ce, frame_done); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (frame_done !== 1'b0)
        begin miscompares++; $display("FAIL abort_nodone i=%0d got=%b want=0", i, frame_done); end
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || src_rdy !== 1'b0)
      begin miscompares++; $display("FAIL abort_wins busy=%b rdy=%b want 0 0", busy, src_rdy); end
  endtask

  task automatic test_rst_drain();
    do_reset();
    begin_frame();
    feed_frame(1'b0);
    tick();
    core_iscorner = 1'b1; core_x = CW'(2); core_y = CW'(1);
    tick();
    vectors++;
    if (corner_vld !== 1'b1 || corner_cnt !== NW'(1))
      begin miscompares++; $display("FAIL rst_pre vld=%b cnt=%0d want 1 1", corner_vld, corner_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0; core_iscorner = 1'b0; core_x = '0; core_y = '0;
    vectors++;
    if ({busy, src_rdy, core_ce, core_data, corner_vld, corner_x, corner_y, corner_cnt,
         frame_done, timeout_err, overflow} !== '0)
      begin miscompares++; $display("FAIL rst_mid busy=%b data=%h vld=%b cnt=%0d want all 0", busy, core_data, corner_vld, corner_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bubbles();
    test_corner_cap();
    test_timeout();
    test_early_eof();
    test_abort_start();
    test_rst_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
